// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl - memory stage of the WISC 16-bit pipeline.
//
// Sits directly after the ALU. LW/SW are sent to data memory over a req/ack
// handshake. Upstream is stalled while an access is outstanding. All other
// results go to writeback one cycle after capture.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   ex_valid            EX presents an instruction (captured when !stall)
//   ex_opcode           4-bit opcode (8 = LW, 9 = SW)
//   ex_alu_out          ALU result / effective address
//   ex_store_data       SW data
//   ex_dst_reg          destination register id
//   stall               upstream must hold EX outputs (combinational)
//   mem_req/mem_wr      memory request, 1 = write
//   mem_addr/mem_wdata  word-aligned address, write data
//   mem_rdata/mem_ack   read data, qualified by the 1-cycle ack pulse
//   wb_valid/wb_we      writeback slot valid pulse, register write enable
//   wb_dst_reg/wb_data  writeback register id and data
//   mem_err             1-cycle pulse when an access is aborted on timeout
// -----------------------------------------------------------------------------
module mem_stage_ctrl #(
    parameter int DATA_W  = 16,
    parameter int REG_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [3:0]        ex_opcode,
    input  logic [DATA_W-1:0] ex_alu_out,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_W-1:0]  ex_dst_reg,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [REG_W-1:0]  wb_dst_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic              mem_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [3:0] OP_LW = 4'h8;
    localparam logic [3:0] OP_SW = 4'h9;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    // Register write enable for non-memory opcodes: B, BR and HLT write nothing.
    function automatic logic wb_we_of(input logic [3:0] op);
        logic we;
        case (op)
            4'hC, 4'hD, 4'hF: we = 1'b0;
            default:          we = 1'b1;
        endcase
        return we;
    endfunction

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_mem_req;
    logic                r_mem_wr;
    logic [DATA_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_is_lw;
    logic [REG_W-1:0]    r_acc_dst;
    // One-entry holding slot for a non-memory result captured in the same
    // cycle an older writeback is emitted; it drains on the next edge.
    logic                r_pend_valid;
    logic                r_pend_we;
    logic [REG_W-1:0]    r_pend_dst;
    logic [DATA_W-1:0]   r_pend_data;
    logic                r_wb_valid;
    logic                r_wb_we;
    logic [REG_W-1:0]    r_wb_dst;
    logic [DATA_W-1:0]   r_wb_data;
    logic                r_mem_err;

    logic w_stall;
    logic w_capture;
    logic w_is_mem;
    logic w_new_mem;
    logic w_new_nonmem;
    logic w_done_ack;
    logic w_done_to;
    logic w_old_valid;

    assign w_stall      = (r_state == ST_ACCESS) && !mem_ack;
    assign w_capture    = ex_valid && !w_stall;
    assign w_is_mem     = (ex_opcode == OP_LW) || (ex_opcode == OP_SW);
    assign w_new_mem    = w_capture && w_is_mem;
    assign w_new_nonmem = w_capture && !w_is_mem;
    assign w_done_ack   = (r_state == ST_ACCESS) && mem_ack;
    assign w_done_to    = (r_state == ST_ACCESS) && !mem_ack && (r_cnt == CNT_LAST);
    // The holding slot is always empty while in ACCESS, so at most one older
    // writeback competes with a newly captured non-memory result.
    assign w_old_valid  = w_done_ack || w_done_to || r_pend_valid;

    // Access FSM, writeback ordering and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_mem_req    <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_is_lw      <= 1'b0;
            r_acc_dst    <= '0;
            r_pend_valid <= 1'b0;
            r_pend_we    <= 1'b0;
            r_pend_dst   <= '0;
            r_pend_data  <= '0;
            r_wb_valid   <= 1'b0;
            r_wb_we      <= 1'b0;
            r_wb_dst     <= '0;
            r_wb_data    <= '0;
            r_mem_err    <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_mem_err  <= 1'b0;

            // Oldest pending writeback goes out first.
            if (w_done_ack) begin
                r_wb_valid <= 1'b1;
                r_wb_we    <= r_is_lw;
                r_wb_dst   <= r_acc_dst;
                if (r_is_lw) begin
                    r_wb_data <= mem_rdata;
                end else begin
                    r_wb_data <= r_wb_data;
                end
            end else if (w_done_to) begin
                r_wb_valid <= 1'b1;
                r_wb_we    <= 1'b0;
                r_wb_dst   <= r_acc_dst;
                r_mem_err  <= 1'b1;
            end else if (r_pend_valid) begin
                r_wb_valid <= 1'b1;
                r_wb_we    <= r_pend_we;
                r_wb_dst   <= r_pend_dst;
                r_wb_data  <= r_pend_data;
            end else begin
                r_wb_we    <= r_wb_we;
            end

            // A new non-memory result either goes straight out or waits a cycle.
            r_pend_valid <= w_new_nonmem && w_old_valid;
            if (w_new_nonmem) begin
                if (w_old_valid) begin
                    r_pend_we   <= wb_we_of(ex_opcode);
                    r_pend_dst  <= ex_dst_reg;
                    r_pend_data <= ex_alu_out;
                end else begin
                    r_wb_valid  <= 1'b1;
                    r_wb_we     <= wb_we_of(ex_opcode);
                    r_wb_dst    <= ex_dst_reg;
                    r_wb_data   <= ex_alu_out;
                end
            end else begin
                r_pend_data <= r_pend_data;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_new_mem) begin
                        r_state     <= ST_ACCESS;
                        r_mem_req   <= 1'b1;
                        r_mem_wr    <= (ex_opcode == OP_SW);
                        r_mem_addr  <= {ex_alu_out[DATA_W-1:1], 1'b0};
                        r_mem_wdata <= ex_store_data;
                        r_is_lw     <= (ex_opcode == OP_LW);
                        r_acc_dst   <= ex_dst_reg;
                        r_cnt       <= '0;
                    end else begin
                        r_state     <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (mem_ack) begin
                        // Upstream advances in the ack cycle; a new LW/SW
                        // keeps mem_req high with the new address/data.
                        if (w_new_mem) begin
                            r_state     <= ST_ACCESS;
                            r_mem_req   <= 1'b1;
                            r_mem_wr    <= (ex_opcode == OP_SW);
                            r_mem_addr  <= {ex_alu_out[DATA_W-1:1], 1'b0};
                            r_mem_wdata <= ex_store_data;
                            r_is_lw     <= (ex_opcode == OP_LW);
                            r_acc_dst   <= ex_dst_reg;
                            r_cnt       <= '0;
                        end else begin
                            r_state     <= ST_IDLE;
                            r_mem_req   <= 1'b0;
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        r_state   <= ST_IDLE;
                        r_mem_req <= 1'b0;
                    end else begin
                        r_cnt     <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign stall      = w_stall;
    assign mem_req    = r_mem_req;
    assign mem_wr     = r_mem_wr;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign wb_valid   = r_wb_valid;
    assign wb_we      = r_wb_we;
    assign wb_dst_reg = r_wb_dst;
    assign wb_data    = r_wb_data;
    assign mem_err    = r_mem_err;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic [3:0]  ex_opcode = 4'h0;
    logic [15:0] ex_alu_out = 16'h0000;
    logic [15:0] ex_store_data = 16'h0000;
    logic [3:0]  ex_dst_reg = 4'h0;
    logic        stall;
    logic        mem_req;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_ack = 1'b0;
    logic        wb_valid;
    logic        wb_we;
    logic [3:0]  wb_dst_reg;
    logic [15:0] wb_data;
    logic        mem_err;

    int n_tests = 0;
    int n_fail  = 0;

    mem_stage_ctrl #(.DATA_W(16), .REG_W(4), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data), .ex_dst_reg(ex_dst_reg),
        .stall(stall), .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_dst_reg(wb_dst_reg),
        .wb_data(wb_data), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [3:0]  op;
        logic [15:0] alu;
        logic [3:0]  dst;
        logic        exp_we;
    } vec_t;

    typedef struct {
        logic        we;
        logic [3:0]  dst;
        logic [15:0] data;
        logic        err;
    } exp_t;

    vec_t vecs[10];
    exp_t exp_q[$];
    int   dly_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] alu,
                         input logic [15:0] sd, input logic [3:0] dst);
        ex_valid = v; ex_opcode = op; ex_alu_out = alu; ex_store_data = sd; ex_dst_reg = dst;
    endtask

    task automatic run_random();
        int   ops = 0;
        int   cyc = 0;
        int   idle = 0;
        int   dly = 0;
        int   cnt = 0;
        bit   busy = 1'b0;
        bit   take = 1'b1;
        exp_t e;
        while (cyc < 20000 && (ops < 500 || idle < 20)) begin
            @(negedge clk);
            cyc++;
            if (ops >= 500) idle++;
            // writeback monitor
            if (wb_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_extra_wb", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rnd_we", wb_we, e.we);
                    chk("rnd_dst", wb_dst_reg, e.dst);
                    chk("rnd_err", mem_err, e.err);
                    if (e.we) chk("rnd_data", wb_data, e.data);
                end
            end else if (mem_err) begin
                chk("rnd_err_no_wb", mem_err, 1'b0);
            end
            // memory responder
            if (!mem_req) begin
                busy = 1'b0;
                mem_ack = 1'b0;
            end else begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt = 0;
                    if (dly_q.size() == 0) begin
                        chk("rnd_unexpected_req", 32'd1, 32'd0);
                        dly = 0;
                    end else begin
                        dly = dly_q.pop_front();
                    end
                end else begin
                    cnt++;
                end
                if (cnt == dly) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem_addr ^ 16'h5A5A;
                    busy = 1'b0;
                end else begin
                    mem_ack = 1'b0;
                end
            end
            // instruction driver
            if (take) begin
                if (ops < 500 && $urandom_range(0, 3) != 0)
                    drive(1'b1, 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
                          4'($urandom_range(0, 15)));
                else
                    ex_valid = 1'b0;
            end
            #1;
            take = !(ex_valid && stall);
            if (ex_valid && !stall) begin
                ops++;
                if (ex_opcode == 4'h8 || ex_opcode == 4'h9) begin
                    dly = $urandom_range(0, 5);
                    dly_q.push_back(dly);
                    e.err  = (dly >= 4);
                    e.we   = (ex_opcode == 4'h8) && (dly < 4);
                    e.data = {ex_alu_out[15:1], 1'b0} ^ 16'h5A5A;
                end else begin
                    e.err  = 1'b0;
                    e.we   = !(ex_opcode == 4'hC || ex_opcode == 4'hD || ex_opcode == 4'hF);
                    e.data = ex_alu_out;
                end
                e.dst = ex_dst_reg;
                exp_q.push_back(e);
            end
        end
        chk("rnd_ops_done", ops, 500);
        chk("rnd_lost_wb", exp_q.size(), 0);
        mem_ack = 1'b0;
        ex_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] last_data;
        vecs[0] = '{1'b1, 4'h0, 16'h1234, 4'h3, 1'b1};
        vecs[1] = '{1'b1, 4'h1, 16'hFFFF, 4'h0, 1'b1};
        vecs[2] = '{1'b1, 4'h7, 16'h8001, 4'hF, 1'b1};
        vecs[3] = '{1'b1, 4'hA, 16'h00AA, 4'h4, 1'b1};
        vecs[4] = '{1'b1, 4'hB, 16'hAA00, 4'h5, 1'b1};
        vecs[5] = '{1'b1, 4'hC, 16'h0100, 4'h6, 1'b0};
        vecs[6] = '{1'b1, 4'hD, 16'h0200, 4'h7, 1'b0};
        vecs[7] = '{1'b1, 4'hE, 16'h0202, 4'h8, 1'b1};
        vecs[8] = '{1'b1, 4'hF, 16'h0000, 4'h9, 1'b0};
        vecs[9] = '{1'b0, 4'h0, 16'h7777, 4'h1, 1'b0};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_stall", stall, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_wr", mem_wr, 1'b0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_mem_wdata", mem_wdata, 16'h0000);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_wb_we", wb_we, 1'b0);
        chk("rst_wb_dst", wb_dst_reg, 4'h0);
        chk("rst_wb_data", wb_data, 16'h0000);
        chk("rst_mem_err", mem_err, 1'b0);
        rst_n = 1'b1;

        // table-driven non-memory pass-through, back to back
        last_data = 16'h0000;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].vld, vecs[i].op, vecs[i].alu, 16'h0000, vecs[i].dst);
            @(negedge clk);
            chk("vec_wb_valid", wb_valid, vecs[i].vld);
            chk("vec_stall", stall, 1'b0);
            if (vecs[i].vld) begin
                chk("vec_wb_we", wb_we, vecs[i].exp_we);
                chk("vec_wb_data", wb_data, vecs[i].alu);
                chk("vec_wb_dst", wb_dst_reg, vecs[i].dst);
                last_data = vecs[i].alu;
            end else begin
                chk("vec_wb_data_hold", wb_data, last_data);
            end
        end
        ex_valid = 1'b0;

        // LW acked in the third request cycle
        @(negedge clk);
        drive(1'b1, 4'h8, 16'h0041, 16'h0000, 4'h5);
        @(negedge clk);
        ex_valid = 1'b0;
        chk("lw_req", mem_req, 1'b1);
        chk("lw_addr", mem_addr, 16'h0040);
        chk("lw_wr", mem_wr, 1'b0);
        chk("lw_stall1", stall, 1'b1);
        @(negedge clk);
        chk("lw_stall2", stall, 1'b1);
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        #1;
        chk("lw_stall_ack", stall, 1'b0);
        @(negedge clk);
        mem_ack = 1'b0;
        chk("lw_wb_valid", wb_valid, 1'b1);
        chk("lw_wb_we", wb_we, 1'b1);
        chk("lw_wb_data", wb_data, 16'hBEEF);
        chk("lw_wb_dst", wb_dst_reg, 4'h5);
        chk("lw_req_drop", mem_req, 1'b0);

        // SW then LW back to back, immediate acks
        drive(1'b1, 4'h9, 16'h0102, 16'hCAFE, 4'h1);
        @(negedge clk);
        chk("sw_req", mem_req, 1'b1);
        chk("sw_wr", mem_wr, 1'b1);
        chk("sw_addr", mem_addr, 16'h0102);
        chk("sw_wdata", mem_wdata, 16'hCAFE);
        mem_ack = 1'b1;
        drive(1'b1, 4'h8, 16'h0203, 16'h0000, 4'h2);
        @(negedge clk);
        chk("b2b_sw_wb_valid", wb_valid, 1'b1);
        chk("b2b_sw_wb_we", wb_we, 1'b0);
        chk("b2b_req_held", mem_req, 1'b1);
        chk("b2b_lw_wr", mem_wr, 1'b0);
        chk("b2b_lw_addr", mem_addr, 16'h0202);
        mem_ack = 1'b1; mem_rdata = 16'h1357; ex_valid = 1'b0;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("b2b_lw_wb_valid", wb_valid, 1'b1);
        chk("b2b_lw_wb_we", wb_we, 1'b1);
        chk("b2b_lw_wb_data", wb_data, 16'h1357);
        chk("b2b_lw_wb_dst", wb_dst_reg, 4'h2);
        chk("b2b_req_drop", mem_req, 1'b0);

        // timeout: LW never acked
        drive(1'b1, 4'h8, 16'h0010, 16'h0000, 4'h7);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ex_valid = 1'b0;
            chk("to_req_high", mem_req, 1'b1);
            chk("to_err_low", mem_err, 1'b0);
        end
        @(negedge clk);
        chk("to_req_drop", mem_req, 1'b0);
        chk("to_err", mem_err, 1'b1);
        chk("to_wb_valid", wb_valid, 1'b1);
        chk("to_wb_we", wb_we, 1'b0);
        chk("to_stall", stall, 1'b0);
        @(negedge clk);
        chk("to_err_pulse", mem_err, 1'b0);
        chk("to_wb_pulse", wb_valid, 1'b0);

        // async reset mid-ACCESS, stray ack, then ADD
        drive(1'b1, 4'h8, 16'h0800, 16'h0000, 4'h1);
        @(negedge clk);
        ex_valid = 1'b0;
        chk("ar_req_before", mem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_req_async", mem_req, 1'b0);
        chk("ar_stall_async", stall, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("stray_ack_wb", wb_valid, 1'b0);
        chk("stray_ack_req", mem_req, 1'b0);
        drive(1'b1, 4'h0, 16'h4321, 16'h0000, 4'h2);
        @(negedge clk);
        ex_valid = 1'b0;
        chk("ar_add_wb_valid", wb_valid, 1'b1);
        chk("ar_add_wb_we", wb_we, 1'b1);
        chk("ar_add_wb_data", wb_data, 16'h4321);
        chk("ar_add_wb_dst", wb_dst_reg, 4'h2);

        // random mix against the scoreboard
        @(negedge clk);
        run_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
